fetch_pc: RTL and testbench
===========================

Name: fetch_pc

Overview:
- Instruction-fetch stage directly downstream of the branch unit: consumes its redirect_valid / target PC and produces the next fetch address.
- Owns the architectural fetch PC, issues single-outstanding requests on the instruction bus, and hands fetched instructions to decode over a valid/ready handshake.
- Squashes wrong-path fetches whenever a redirect arrives.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, fetch PC loaded by reset.
- INSTR_W, 32, instruction width returned by the bus.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch unit requests a control-flow change this cycle.
- redirect_pc  in  64  redirect target (branch unit br_out).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  64  fetch address.
- imem_req_ready  in  1  bus accepts the request this cycle.
- imem_resp_valid  in  1  instruction data valid (one-cycle pulse).
- imem_resp_data  in  INSTR_W  instruction word.
- if_valid  out  1  fetched instruction valid to decode.
- if_pc  out  64  PC of the fetched instruction.
- if_instr  out  INSTR_W  fetched instruction.
- if_ready  in  1  decode accepts the instruction.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - pc = PC_RESET; state = IDLE; pend_valid = 0; pend_pc = 0; instr register = 0.
  - All outputs are 0 except imem_req_addr = if_pc = PC_RESET.
- States:
  - IDLE: no request. Always moves to REQ on the next cycle; the first request appears 1 cycle after reset deasserts.
  - REQ: imem_req_valid = 1, imem_req_addr = pc.
    - The address is held stable until imem_req_ready.
    - Handshake with no pending redirect -> WAIT.
    - Handshake with a pending redirect (from this cycle or earlier) -> DROP.
    - Redirect before the handshake: capture pend_pc = redirect_pc, pend_valid = 1. The request address does not change.
  - WAIT: one request is outstanding.
    - imem_resp_valid with no redirect and no pending redirect: latch the instruction -> HOLD.
    - imem_resp_valid with a redirect this cycle or pend_valid: discard the data; pc = newest target; clear pend -> REQ.
    - Redirect without a response: capture pend -> DROP.
  - DROP: waits for the stale response.
    - Further redirects overwrite pend_pc (newest wins).
    - On imem_resp_valid: discard; pc = pend_pc (or redirect_pc if a redirect occurs the same cycle); clear pend -> REQ.
  - HOLD:
    - if_valid = 1 & ~redirect_valid; if_pc = pc; if_instr = latched word.
    - if_ready with no redirect: pc = pc + 4 -> REQ.
    - Redirect (wins over if_ready): if_valid forced 0 this cycle; pc = redirect_pc -> REQ.
    - If if_ready stays low, if_pc and if_instr stay stable indefinitely.
- Outside HOLD, if_valid = 0.
- In IDLE, REQ and HOLD, imem_resp_valid is ignored (no outstanding request).
- Arithmetic and alignment:
  - pc + 4 is computed modulo 2^64 (wraps silently).
  - redirect_pc is taken unmodified: the low 2 bits are not checked and no misalignment trap is raised.
  - No compressed-instruction support.
- Latency:
  - Requests are issued only after reset and after consumption or redirect; at most one is outstanding.
  - Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD with ready=1, resp=1-cycle).
- Reset mid-transaction: any outstanding response is abandoned. The bus is required to drop it, and fetch_pc ignores it in IDLE/REQ.

Decomposition:
- Shared package: fetch_state_t enum {IDLE, REQ, WAIT, DROP, HOLD}; PC_RESET default constant; INSTR_W constant.
- Next-PC selection (redirect > pend > pc+4) stays inline.
- No sub-module; a single module with one state register and one PC register is sufficient.

Test Plan:
- Reset release, ready=1, response 2 cycles later with data 32'h0000_0013 -> request addr 0x8000_0000; if_valid with if_pc 0x8000_0000 and if_instr 0x13; with if_ready=1 the next request addr is 0x8000_0004.
- if_ready held 0 for 5 cycles in HOLD -> if_valid stays 1 with if_pc/if_instr stable; no imem_req_valid; first request 1 cycle after if_ready=1.
- Redirect to 0x8000_1000 in WAIT, response arrives 3 cycles later -> response discarded, if_valid never 1 for the old PC, next request addr 0x8000_1000.
- Redirect to 0x8000_2000 in HOLD with if_ready=1 the same cycle -> if_valid 0 that cycle, next request addr 0x8000_2000 (not pc+4).
- In DROP, redirects to 0x100 then 0x200 before the response -> next request addr 0x200; request 0x100 never issued.
- Redirect 0x300 in REQ while imem_req_ready=0 for 2 cycles -> imem_req_addr unchanged until the handshake, then DROP; following request addr 0x300.
- reset pulsed in WAIT, stale imem_resp_valid arriving after deassert -> outputs cleared immediately; stale response ignored; first request addr 0x8000_0000.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the instruction-fetch PC stage: state encoding,
// reset/width defaults and the sequential next-PC helper.
package fetch_pc_pkg;

  // IDLE: one cycle after reset, no request.
  // REQ : request presented on the bus, address held until accepted.
  // WAIT: request accepted, response expected.
  // DROP: request accepted but a redirect arrived; response will be discarded.
  // HOLD: instruction latched and offered to decode.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int          INSTR_W_DEFAULT  = 32;

  // Sequential successor: fixed 4-byte instructions, wraps modulo 2^64.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch PC stage: owns the architectural fetch PC, issues one outstanding
// instruction-bus request at a time, hands instructions to decode, and
// squashes wrong-path fetches when the branch unit redirects.
//
// Handshakes: a transfer happens on a rising clock edge where the producer's
// valid and the consumer's ready are both high. While valid is high and ready
// is low, the producer holds its payload (imem_req_addr, or if_pc/if_instr)
// stable. The one exception is if_valid, which a same-cycle redirect drops.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          INSTR_W  = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  output logic               imem_req_valid,
  output logic [63:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  output logic [63:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               if_ready
);

  fetch_state_t       state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [63:0]        pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Newest known target: a redirect this cycle beats an earlier pending one.
  logic [63:0]        newest_target;
  assign newest_target = redirect_valid ? redirect_pc : pend_pc_q;

  // State, PC, pending-redirect and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 64'd0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
    end
  end

  // Next-state and next-PC selection (redirect > pending > pc+4).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    instr_d      = instr_q;

    unique case (state_q)
      IDLE: begin
        // No request outstanding yet, so a redirect can retarget directly.
        state_d = REQ;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
      end

      REQ: begin
        // The request address is pc_q and must not move before acceptance;
        // redirects are parked in pend until the stale response returns.
        if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
        if (imem_req_ready) begin
          if (redirect_valid || pend_valid_q) begin
            state_d = DROP;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid || pend_valid_q) begin
            pc_d         = newest_target;
            pend_valid_d = 1'b0;
            pend_pc_d    = 64'd0;
            state_d      = REQ;
          end else begin
            instr_d = imem_resp_data;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
          state_d      = DROP;
        end
      end

      DROP: begin
        if (imem_resp_valid) begin
          pc_d         = newest_target;
          pend_valid_d = 1'b0;
          pend_pc_d    = 64'd0;
          state_d      = REQ;
        end else if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
      end

      HOLD: begin
        // Redirect wins over a same-cycle consume.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (if_ready) begin
          pc_d    = next_seq_pc(pc_q);
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request and decode-side outputs are decoded from the state register.
  always_comb begin
    imem_req_valid = (state_q == REQ);
    imem_req_addr  = pc_q;
    if_valid       = (state_q == HOLD) && !redirect_valid;
    if_pc          = pc_q;
    if_instr       = instr_q;
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc with an expected-value scoreboard: stimulus
// pushes expected bus requests and decode outputs; a monitor on the falling
// edge compares whatever the DUT presents against the queue heads.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  logic [63:0] req_exp_q[$];
  logic [95:0] if_exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  fetch_pc #(.PC_RESET(PC_RST), .INSTR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Comparison helper.
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare presented outputs to queue heads, pop on transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req_valid) begin
        if (req_exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_req: got addr %0h expected no request", imem_req_addr);
        end else begin
          check("req_addr", {32'd0, imem_req_addr}, {32'd0, req_exp_q[0]});
          if (imem_req_ready) void'(req_exp_q.pop_front());
        end
      end
      if (if_valid) begin
        if (if_exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_if: got pc %0h instr %0h expected no instruction", if_pc, if_instr);
        end else begin
          check("if_pc_instr", {if_pc, if_instr}, if_exp_q[0]);
          if (if_ready) void'(if_exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
  endtask

  // From REQ at addr: accept, wait gap cycles, deliver data, land in HOLD.
  task automatic fetch_to_hold(input logic [63:0] addr, input logic [31:0] data, input int gap);
    handshake();
    repeat (gap) step();
    if_exp_q.push_back({addr, data});
    respond(data);
  endtask

  task automatic consume_to(input logic [63:0] next_addr);
    req_exp_q.push_back(next_addr);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic set_redirect(input logic v, input logic [63:0] pc);
    redirect_valid = v;
    redirect_pc    = pc;
  endtask

  // Directed stimulus.
  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    if_ready = 1'b0;
    repeat (2) step();

    // Reset values.
    check("rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    check("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, PC_RST});
    check("rst_if_valid", {95'd0, if_valid}, 96'd0);
    check("rst_if_pc", {32'd0, if_pc}, {32'd0, PC_RST});
    check("rst_if_instr", {64'd0, if_instr}, 96'd0);

    // Basic fetch: first request one cycle after release.
    req_exp_q.push_back(PC_RST);
    reset = 1'b0;
    check("idle_no_req", {95'd0, imem_req_valid}, 96'd0);
    step();
    check("first_req_valid", {95'd0, imem_req_valid}, 96'd1);
    fetch_to_hold(PC_RST, 32'h0000_0013, 1);
    consume_to(64'h8000_0004);

    // Decode stalls five cycles in HOLD.
    fetch_to_hold(64'h8000_0004, 32'h0010_0093, 0);
    repeat (5) step();
    check("stall_no_req", {95'd0, imem_req_valid}, 96'd0);
    check("stall_if_valid", {95'd0, if_valid}, 96'd1);
    consume_to(64'h8000_0008);
    check("req_after_consume", {95'd0, imem_req_valid}, 96'd1);

    // Redirect in WAIT, stale response three cycles later.
    handshake();
    set_redirect(1'b1, 64'h8000_1000);
    step();
    set_redirect(1'b0, 64'd0);
    repeat (2) step();
    req_exp_q.push_back(64'h8000_1000);
    respond(32'hdead_beef);
    check("wait_discard_if_valid", {95'd0, if_valid}, 96'd0);

    // Redirect in HOLD together with if_ready: redirect wins.
    fetch_to_hold(64'h8000_1000, 32'h0050_0093, 0);
    set_redirect(1'b1, 64'h8000_2000);
    if_ready = 1'b1;
    #1;
    check("hold_redirect_kills_valid", {95'd0, if_valid}, 96'd0);
    void'(if_exp_q.pop_front());
    req_exp_q.push_back(64'h8000_2000);
    step();
    set_redirect(1'b0, 64'd0);
    if_ready = 1'b0;

    // Wrap of pc + 4 at the top of the address space.
    fetch_to_hold(64'h8000_2000, 32'h0060_0093, 1);
    set_redirect(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    void'(if_exp_q.pop_front());
    req_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    set_redirect(1'b0, 64'd0);
    fetch_to_hold(64'hFFFF_FFFF_FFFF_FFFC, 32'h0070_0093, 0);
    consume_to(64'h0);

    // Two redirects in DROP: newest wins.
    handshake();
    set_redirect(1'b1, 64'h100);
    step();
    set_redirect(1'b1, 64'h200);
    step();
    set_redirect(1'b0, 64'd0);
    req_exp_q.push_back(64'h200);
    respond(32'hbad0_0001);

    // Redirect in REQ while the bus stalls: address held, then DROP.
    set_redirect(1'b1, 64'h300);
    step();
    set_redirect(1'b0, 64'd0);
    step();
    check("req_addr_held", {32'd0, imem_req_addr}, {32'd0, 64'h200});
    handshake();
    step();
    req_exp_q.push_back(64'h300);
    respond(32'hbad0_0002);
    fetch_to_hold(64'h300, 32'h0080_0093, 0);
    consume_to(64'h304);

    // Response and redirect in the same WAIT cycle; misaligned target kept as-is.
    handshake();
    set_redirect(1'b1, 64'h402);
    req_exp_q.push_back(64'h402);
    respond(32'hbad0_0003);
    set_redirect(1'b0, 64'd0);
    fetch_to_hold(64'h402, 32'h0090_0093, 0);
    consume_to(64'h406);

    // Reset while a request is outstanding.
    handshake();
    reset = 1'b1;
    #1;
    check("mid_rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    check("mid_rst_req_addr", {32'd0, imem_req_addr}, {32'd0, PC_RST});
    check("mid_rst_if_pc", {32'd0, if_pc}, {32'd0, PC_RST});
    check("mid_rst_if_instr", {64'd0, if_instr}, 96'd0);
    step();
    reset = 1'b0;
    req_exp_q.push_back(PC_RST);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hbad0_0004;
    step();
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    check("stale_resp_if_valid", {95'd0, if_valid}, 96'd0);
    fetch_to_hold(PC_RST, 32'h0000_0013, 1);
    consume_to(64'h8000_0004);
    handshake();
    step();

    check("req_q_drained", {64'd0, 32'(req_exp_q.size())}, 96'd0);
    check("if_q_drained", {64'd0, 32'(if_exp_q.size())}, 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
